// File: rtl/vm_pkg.sv
// Shared types and constants for the change-return sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: coin_t (eject encoding, 2'b00 = no coin), seq_state_t (sequencer FSM states),
//           coin face values in cents, and coin_val() mapping a coin to its value.
package vm_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    NICKEL    = 2'b01,
    DIME      = 2'b10,
    QUARTER   = 2'b11
  } coin_t;

  typedef enum logic [2:0] {
    IDLE,
    EJECT,
    GAP,
    DONE,
    ERR
  } seq_state_t;

  localparam logic [7:0] NICKEL_VAL  = 8'd5;
  localparam logic [7:0] DIME_VAL    = 8'd10;
  localparam logic [7:0] QUARTER_VAL = 8'd25;

  function automatic logic [7:0] coin_val(input coin_t c);
    case (c)
      NICKEL:  return NICKEL_VAL;
      DIME:    return DIME_VAL;
      QUARTER: return QUARTER_VAL;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_sequencer_if.sv
// Request/ejector/status bundle of the change sequencer.
// Latency: n/a (wires only).
// Backpressure: coin_done is the ejector acknowledge; start is dropped while busy.
// Modports: master = requester/ejector side, slave = change_sequencer.
// With CHANGE_INV_EN defined the bundle also carries the coin inventory load/count signals.
interface change_sequencer_if;
  import vm_pkg::*;

  logic       start;
  logic [7:0] amount;
  logic       coin_done;
  coin_t      eject;
  logic       eject_valid;
  logic [7:0] remaining;
  logic       busy;
  logic       done;
  logic       error;
`ifdef CHANGE_INV_EN
  logic       inv_load;
  logic [3:0] inv_q;
  logic [3:0] inv_d;
  logic [3:0] inv_n;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [3:0] cnt_n;
`endif

  modport master (
    output start, amount, coin_done,
`ifdef CHANGE_INV_EN
    output inv_load, inv_q, inv_d, inv_n,
    input  cnt_q, cnt_d, cnt_n,
`endif
    input  eject, eject_valid, remaining, busy, done, error
  );

  modport slave (
    input  start, amount, coin_done,
`ifdef CHANGE_INV_EN
    input  inv_load, inv_q, inv_d, inv_n,
    output cnt_q, cnt_d, cnt_n,
`endif
    output eject, eject_valid, remaining, busy, done, error
  );

endinterface

// File: rtl/coin_pick.sv
// Greedy coin selector: largest coin not exceeding the owed value (and in stock).
// Latency: combinational.
// Backpressure: none.
// Ports: remaining (cents owed) -> coin (chosen coin), valid (a coin is available).
// With CHANGE_INV_EN defined, cnt_q/cnt_d/cnt_n gate out coin types whose count is 0.
module coin_pick
  import vm_pkg::*;
(
  input  logic [7:0] remaining,
`ifdef CHANGE_INV_EN
  input  logic [3:0] cnt_q,
  input  logic [3:0] cnt_d,
  input  logic [3:0] cnt_n,
`endif
  output coin_t      coin,
  output logic       valid
);

  logic q_ok, d_ok, n_ok;

  always_comb begin
`ifdef CHANGE_INV_EN
    q_ok = (remaining >= QUARTER_VAL) && (cnt_q != 4'd0);
    d_ok = (remaining >= DIME_VAL)    && (cnt_d != 4'd0);
    n_ok = (remaining >= NICKEL_VAL)  && (cnt_n != 4'd0);
`else
    q_ok = (remaining >= QUARTER_VAL);
    d_ok = (remaining >= DIME_VAL);
    n_ok = (remaining >= NICKEL_VAL);
`endif
    coin  = COIN_NONE;
    valid = 1'b0;
    if (q_ok) begin
      coin  = QUARTER;
      valid = 1'b1;
    end else if (d_ok) begin
      coin  = DIME;
      valid = 1'b1;
    end else if (n_ok) begin
      coin  = NICKEL;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/change_sequencer.sv
// Change-return sequencer: pays an amount out as a greedy sequence of coin ejects.
// Latency: start accepted on the next edge; one EJECT per coin, GAP_CYCLES idle between coins.
// Backpressure: each eject is held until coin_done or TIMEOUT_CYCLES expire; start ignored while busy.
// Ports: clk, nrst (async active-low), io (change_sequencer_if.slave: start/amount/coin_done in,
//        eject/eject_valid/remaining/busy/done/error out).
// Optional CHANGE_INV_EN: per-coin inventory (inv_load/inv_q/inv_d/inv_n in, cnt_q/cnt_d/cnt_n out).
module change_sequencer
  import vm_pkg::*;
#(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              nrst,
  change_sequencer_if.slave io
);

  seq_state_t state_q, state_d;
  logic [7:0] rem_q, rem_d;
  coin_t      eject_q, eject_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] gap_q, gap_d;

  logic [7:0] rem_after;
  logic [7:0] pick_rem;
  coin_t      pick_coin;
  logic       pick_ok;

  // Value left once the coin currently presented has been acknowledged.
  assign rem_after = rem_q - coin_val(eject_q);

  // The selector looks at whatever value the next EJECT will start from:
  // the new amount in IDLE, the post-acknowledge value in EJECT (zero-gap
  // back-to-back ejects), and the held value at the end of GAP.
  always_comb begin
    pick_rem = rem_q;
    if (state_q == IDLE)       pick_rem = io.amount;
    else if (state_q == EJECT) pick_rem = rem_after;
  end

`ifdef CHANGE_INV_EN
  logic [3:0] cq_q, cd_q, cn_q, cq_d, cd_d, cn_d;
  logic [3:0] cq_after, cd_after, cn_after;
  logic [3:0] pq, pd, pn;

  always_comb begin
    cq_after = cq_q;
    cd_after = cd_q;
    cn_after = cn_q;
    case (eject_q)
      QUARTER: cq_after = cq_q - 4'd1;
      DIME:    cd_after = cd_q - 4'd1;
      NICKEL:  cn_after = cn_q - 4'd1;
      default: ;
    endcase
  end

  assign pq = (state_q == EJECT) ? cq_after : cq_q;
  assign pd = (state_q == EJECT) ? cd_after : cd_q;
  assign pn = (state_q == EJECT) ? cn_after : cn_q;

  assign io.cnt_q = cq_q;
  assign io.cnt_d = cd_q;
  assign io.cnt_n = cn_q;
`endif

  coin_pick u_pick (
    .remaining (pick_rem),
`ifdef CHANGE_INV_EN
    .cnt_q     (pq),
    .cnt_d     (pd),
    .cnt_n     (pn),
`endif
    .coin      (pick_coin),
    .valid     (pick_ok)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    eject_d = COIN_NONE;   // eject reads 2'b00 whenever we are not in EJECT
    wait_d  = 8'd0;
    gap_d   = 4'd0;
`ifdef CHANGE_INV_EN
    cq_d = cq_q;
    cd_d = cd_q;
    cn_d = cn_q;
`endif
    case (state_q)
      IDLE: begin
        if (io.start) begin
          rem_d = io.amount;
          if ((io.amount % 8'd5) != 8'd0) begin
            state_d = ERR;
          end else if (io.amount == 8'd0) begin
            state_d = DONE;
          end else if (pick_ok) begin
            state_d = EJECT;
            eject_d = pick_coin;
          end else begin
            state_d = ERR;
          end
        end
`ifdef CHANGE_INV_EN
        else if (io.inv_load) begin
          cq_d = io.inv_q;
          cd_d = io.inv_d;
          cn_d = io.inv_n;
        end
`endif
      end
      EJECT: begin
        if (io.coin_done) begin
          rem_d = rem_after;
`ifdef CHANGE_INV_EN
          cq_d = cq_after;
          cd_d = cd_after;
          cn_d = cn_after;
`endif
          if (rem_after == 8'd0) begin
            state_d = DONE;
          end else if (GAP_CYCLES == 0) begin
            if (pick_ok) begin
              eject_d = pick_coin;
            end else begin
              state_d = ERR;
            end
          end else begin
            state_d = GAP;
          end
        end else if (wait_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = ERR;
        end else begin
          wait_d  = wait_q + 8'd1;
          eject_d = eject_q;
        end
      end
      GAP: begin
        if (gap_q == 4'(GAP_CYCLES - 1)) begin
          if (pick_ok) begin
            state_d = EJECT;
            eject_d = pick_coin;
          end else begin
            state_d = ERR;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      rem_q   <= 8'd0;
      eject_q <= COIN_NONE;
      wait_q  <= 8'd0;
      gap_q   <= 4'd0;
`ifdef CHANGE_INV_EN
      cq_q    <= 4'd0;
      cd_q    <= 4'd0;
      cn_q    <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      eject_q <= eject_d;
      wait_q  <= wait_d;
      gap_q   <= gap_d;
`ifdef CHANGE_INV_EN
      cq_q    <= cq_d;
      cd_q    <= cd_d;
      cn_q    <= cn_d;
`endif
    end
  end

  assign io.eject       = eject_q;
  assign io.eject_valid = (state_q == EJECT);
  assign io.remaining   = rem_q;
  assign io.busy        = (state_q != IDLE);
  assign io.done        = (state_q == DONE);
  assign io.error       = (state_q == ERR);

endmodule

// File: tb/tb_change_sequencer.sv
`timescale 1ns/1ps
module tb_change_sequencer;
  import vm_pkg::*;

  localparam int GAP = 2;
  localparam int TMO = 255;
  localparam int EV_COIN = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int kind;
    int coin;
    int rem;
    int aux;   // coin: idle busy cycles before it; done/err: busy cycles before it
  } ev_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  logic ack_mode = 1'b0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  change_sequencer_if sif ();

  change_sequencer #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .io   (sif)
  );

  always #5 clk = ~clk;

  // Ejector model: acknowledges on the first cycle a coin is presented when ack_mode is set.
  initial begin
    sif.coin_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      sif.coin_done = ack_mode && sif.eject_valid;
    end
  end

  task automatic expect_ev(input int kind, input int coin, input int rem, input int aux);
    ev_t e;
    e.kind = kind; e.coin = coin; e.rem = rem; e.aux = aux;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic post(input int kind, input int coin, input int rem, input int aux);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind=%0d coin=%0d rem=%0d aux=%0d", kind, coin, rem, aux);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.coin != coin || e.rem != rem || e.aux != aux) begin
        errors++;
        $display("FAIL event: got kind=%0d coin=%0d rem=%0d aux=%0d expected kind=%0d coin=%0d rem=%0d aux=%0d",
                 kind, coin, rem, aux, e.kind, e.coin, e.rem, e.aux);
      end
    end
  endtask

  // Monitor
  logic  prev_valid = 1'b0;
  logic  prev_cd    = 1'b0;
  coin_t prev_eject = COIN_NONE;
  int    idle_run   = 0;
  int    busy_cnt   = 0;

  always @(negedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_valid = 1'b0;
      prev_cd    = 1'b0;
      prev_eject = COIN_NONE;
      idle_run   = 0;
      busy_cnt   = 0;
    end else begin
      if (sif.eject_valid && (!prev_valid || prev_cd)) begin
        post(EV_COIN, int'(sif.eject), int'(sif.remaining), idle_run);
      end else if (sif.eject_valid) begin
        check("eject_stable", int'(sif.eject), int'(prev_eject));
      end
      if (!sif.eject_valid) check("eject_idle_zero", int'(sif.eject), 0);
      if (sif.done)  post(EV_DONE, 0, int'(sif.remaining), busy_cnt);
      if (sif.error) post(EV_ERR, 0, int'(sif.remaining), busy_cnt);
      if (sif.done || sif.error) check("valid_low_at_end", int'(sif.eject_valid), 0);
      if (sif.eject_valid)   idle_run = 0;
      else if (sif.busy)     idle_run++;
      else                   idle_run = 0;
      busy_cnt   = sif.busy ? busy_cnt + 1 : 0;
      prev_valid = sif.eject_valid;
      prev_cd    = sif.coin_done;
      prev_eject = sif.eject;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (sif.busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_within_budget", int'(sif.busy), 0);
  endtask

  task automatic run_txn(input logic [7:0] amt, input bit poke);
    @(negedge clk);
    sif.amount = amt;
    sif.start  = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    if (poke) begin
      // start while busy must be dropped
      repeat (2) @(posedge clk);
      #1;
      sif.amount = 8'd15;
      sif.start  = 1'b1;
      @(posedge clk);
      #1;
      sif.start = 1'b0;
    end
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},        int'(sif.busy),        0);
    check({tag, "_eject_valid"}, int'(sif.eject_valid), 0);
    check({tag, "_eject"},       int'(sif.eject),       0);
    check({tag, "_remaining"},   int'(sif.remaining),   0);
    check({tag, "_done"},        int'(sif.done),        0);
    check({tag, "_error"},       int'(sif.error),       0);
  endtask

`ifdef CHANGE_INV_EN
  task automatic load_inv(input logic [3:0] q, input logic [3:0] d, input logic [3:0] n);
    @(negedge clk);
    sif.inv_q = q;
    sif.inv_d = d;
    sif.inv_n = n;
    sif.inv_load = 1'b1;
    @(negedge clk);
    sif.inv_load = 1'b0;
  endtask
`endif

  initial begin
    int n;
    sif.start  = 1'b0;
    sif.amount = 8'd0;
`ifdef CHANGE_INV_EN
    sif.inv_load = 1'b0;
    sif.inv_q = 4'd0;
    sif.inv_d = 4'd0;
    sif.inv_n = 4'd0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    nrst = 1'b1;
`ifdef CHANGE_INV_EN
    load_inv(4'd15, 4'd15, 4'd15);
`endif

    // 40 cents: Q, D, N with GAP idle cycles between, one stray start while busy
    ack_mode = 1'b1;
    expect_ev(EV_COIN, int'(QUARTER), 40, 0);
    expect_ev(EV_COIN, int'(DIME),    15, GAP);
    expect_ev(EV_COIN, int'(NICKEL),   5, GAP);
    expect_ev(EV_DONE, 0, 0, 7);
    run_txn(8'd40, 1'b1);
    check("rem_after_40", int'(sif.remaining), 0);

    // zero amount: done in the cycle right after acceptance, no eject
    expect_ev(EV_DONE, 0, 0, 0);
    run_txn(8'd0, 1'b0);

    // not a multiple of 5: immediate error, remaining holds the amount
    expect_ev(EV_ERR, 0, 23, 0);
    run_txn(8'd23, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rem_hold_23", int'(sif.remaining), 23);

    // ejector never acknowledges: timeout after TMO eject cycles
    ack_mode = 1'b0;
    expect_ev(EV_COIN, int'(DIME), 10, 0);
    expect_ev(EV_ERR, 0, 10, TMO);
    run_txn(8'd10, 1'b0);
    check("rem_after_timeout", int'(sif.remaining), 10);

    // reset in the middle of an eject, then a start on the first edge after release
    expect_ev(EV_COIN, int'(QUARTER), 35, 0);
    @(negedge clk);
    sif.amount = 8'd35;
    sif.start  = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    n = 0;
    while (!sif.eject_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("eject_before_reset", int'(sif.eject_valid), 1);
    @(negedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check_all_zero("midreset");
`ifdef CHANGE_INV_EN
    expect_ev(EV_ERR, 0, 5, 0);   // reset emptied the inventory
`else
    expect_ev(EV_COIN, int'(NICKEL), 5, 0);
    expect_ev(EV_DONE, 0, 0, 1);
`endif
    ack_mode   = 1'b1;
    sif.amount = 8'd5;
    sif.start  = 1'b1;
    nrst       = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    check("busy_first_edge", int'(sif.busy), 1);
    wait_idle();

`ifdef CHANGE_INV_EN
    load_inv(4'd0, 4'd3, 4'd1);
    expect_ev(EV_COIN, int'(DIME), 30, 0);
    expect_ev(EV_COIN, int'(DIME), 20, GAP);
    expect_ev(EV_COIN, int'(DIME), 10, GAP);
    expect_ev(EV_DONE, 0, 0, 7);
    run_txn(8'd30, 1'b0);
    check("cnt_d_after_30", int'(sif.cnt_d), 0);
    expect_ev(EV_COIN, int'(NICKEL), 10, 0);
    expect_ev(EV_ERR, 0, 5, 1 + GAP);
    run_txn(8'd10, 1'b0);
    check("cnt_n_after_10", int'(sif.cnt_n), 0);
`endif

    repeat (5) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_sequencer.md
CHANGE_SEQUENCER -- requirements
Module: change_sequencer

Interface
REQ-001 The block SHALL take parameter GAP_CYCLES, default 2, as the idle cycles between consecutive ejects (range 0-15).
REQ-002 The block SHALL take parameter TIMEOUT_CYCLES, default 255, as the maximum cycles to wait for coin_done (range 1-255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port nrst, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to return change; sampled only in IDLE.
REQ-006 The block SHALL have port amount, input, 8 bits: change owed in cents, captured on an accepted start.
REQ-007 The block SHALL have port coin_done, input, 1 bit: ejector acknowledge for the presented coin.
REQ-008 The block SHALL have port eject, output, 2 bits, coin_t: coin presented (NICKEL/DIME/QUARTER); 2'b00 when not ejecting.
REQ-009 The block SHALL have port eject_valid, output, 1 bit: eject is valid and held stable.
REQ-010 The block SHALL have port remaining, output, 8 bits: cents still owed.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-013 The block SHALL have port error, output, 1 bit: one-cycle pulse on failure.

Function
REQ-014 The FSM SHALL have states IDLE, EJECT, GAP, DONE and ERR.
REQ-015 IDLE with start=1: next edge loads remaining=amount, then goes to ERR if amount%5!=0, to DONE if amount==0, else to EJECT.
REQ-016 Coin choice is greedy on the remaining value loaded into EJECT: QUARTER if >=25, else DIME if >=10, else NICKEL.
REQ-017 Eject is registered and stable for the whole EJECT state; eject_valid=1 only in EJECT.
REQ-018 EJECT with coin_done=1: that edge subtracts the coin value (5/10/25) from remaining, then goes to DONE if the result is 0, else to GAP; if GAP_CYCLES=0, goes directly to EJECT with a newly chosen coin.
REQ-019 GAP SHALL last exactly GAP_CYCLES cycles, then go to EJECT with a newly chosen coin.
REQ-020 coin_done outside EJECT SHALL be ignored.
REQ-021 A wait counter in EJECT reaching TIMEOUT_CYCLES without coin_done SHALL go to ERR; remaining is left unchanged.
REQ-022 DONE and ERR SHALL each last one cycle, assert done or error respectively, then return to IDLE.
REQ-023 remaining SHALL hold its last value in IDLE for inspection until the next accepted start.
REQ-024 start while busy=1 SHALL be ignored, with no queuing.
REQ-025 Subtraction SHALL never underflow: greedy choice guarantees coin value <= remaining.

Reset
REQ-026 nrst=0 SHALL immediately force state to IDLE and clear remaining, eject, eject_valid, busy, done, error and all counters, including mid-EJECT.
REQ-027 The first accepted start SHALL occur on the first rising edge after nrst deasserts.

Configuration
REQ-028 With CHANGE_INV_EN defined, the block SHALL add inputs inv_load (1 bit) and inv_q, inv_d, inv_n (4 bits each), plus outputs cnt_q, cnt_d, cnt_n (4 bits each).
REQ-029 With CHANGE_INV_EN, inv_load=1 in IDLE SHALL load the per-coin counts.
REQ-030 With CHANGE_INV_EN, greedy choice SHALL skip coin types whose count is 0, and each acknowledged eject SHALL decrement that coin's count.
REQ-031 With CHANGE_INV_EN, if remaining>0 and no eligible coin exists, the block SHALL go to ERR.
REQ-032 Without CHANGE_INV_EN, the inventory ports and counters SHALL be absent and supply is treated as unlimited.

Structure
REQ-033 coin_t, the sequencer state enum and constants NICKEL_VAL=5, DIME_VAL=10, QUARTER_VAL=25 SHALL live in shared package vm_pkg.
REQ-034 Greedy selection SHALL be a combinational sub-module coin_pick (inputs: remaining, plus counts when CHANGE_INV_EN; outputs: coin, valid).

Verification
REQ-035 amount=40, coin_done=1 on the first EJECT cycle each time: eject sequence QUARTER, DIME, NICKEL with GAP_CYCLES idle cycles between; done pulses once; remaining=0.
REQ-036 amount=0: done pulses on the second cycle after start; eject_valid never asserts.
REQ-037 amount=23: error pulses once; eject_valid never asserts; remaining=23.
REQ-038 amount=10 with coin_done held 0: error pulses after TIMEOUT_CYCLES EJECT cycles; eject_valid drops; remaining=10.
REQ-039 amount=35 with nrst pulsed low during the first EJECT: all outputs are 0 immediately; a new start=1 with amount=5 then completes normally.
REQ-040 CHANGE_INV_EN, inv_q=0, inv_d=3, inv_n=1, amount=30: three DIME ejects, done, cnt_d=0; a follow-up amount=10 gives NICKEL, then error.
